// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and clear-FSM encoding for the flop register file
package regfile_pkg;
    localparam logic REGFILE_CK_EN_ACTIVE = 1'b1;
    localparam logic REGFILE_WR_ACTIVE = 1'b1;
    localparam logic [31:0] REGFILE_IMPL_MASK_DEFAULT = 32'hFC00_FC0F;
    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} clr_state_e;
endpackage

// File: rtl/regfile_mp_ff_if.sv
// regfile_mp_ff_if: read/write/clear port bundle of the register file
interface regfile_mp_ff_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
    logic clear_req;
    logic [ADDR_W-1:0] address_a, address_b, address_w0, address_w1;
    logic ck_en_a, ck_en_b, we0, we1, ck_en_w0, ck_en_w1;
    logic [DATA_W-1:0] wr_data0, wr_data1, rd_data_a, rd_data_b;
    logic busy, wr_err;
    modport master(
        output clear_req, address_a, address_b, ck_en_a, ck_en_b,
        output address_w0, address_w1, wr_data0, wr_data1, we0, we1, ck_en_w0, ck_en_w1,
        input rd_data_a, rd_data_b, busy, wr_err
    );
    modport slave(
        input clear_req, address_a, address_b, ck_en_a, ck_en_b,
        input address_w0, address_w1, wr_data0, wr_data1, we0, we1, ck_en_w0, ck_en_w1,
        output rd_data_a, rd_data_b, busy, wr_err
    );
endinterface

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: latched read address plus mask-qualified read mux
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter logic [(1<<ADDR_W)-1:0] IMPL_MASK = REGFILE_IMPL_MASK_DEFAULT
) (
    input  logic clk,
    input  logic rst_a,
    input  logic ck_en,
    input  logic [ADDR_W-1:0] address,
    input  logic busy,
    input  logic [DATA_W-1:0] mem [1<<ADDR_W],
    output logic [DATA_W-1:0] rd_data
);
    logic [ADDR_W-1:0] address_r;
    always_ff @(posedge clk or posedge rst_a)
        if (rst_a) address_r <= '0;
        else if (ck_en == REGFILE_CK_EN_ACTIVE) address_r <= address;
    // reads are forced to zero while the array is being cleared
    assign rd_data = busy ? '0 : IMPL_MASK[address_r] ? mem[address_r] : '0;
endmodule

// File: rtl/regfile_mp_ff.sv
// regfile_mp_ff: 2R/2W flop register file with sparse implemented map and clear sequencer
module regfile_mp_ff
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter logic [(1<<ADDR_W)-1:0] IMPL_MASK = REGFILE_IMPL_MASK_DEFAULT
) (
    input logic clk,
    input logic rst_a,
    regfile_mp_ff_if.slave bus
);
    localparam int N = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
    clr_state_e state, state_nx;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_nx;
    logic busy, en0, en1, eff0, eff1, err0, err1, wr_err;
    logic [DATA_W-1:0] mem [N];
    always_ff @(posedge clk or posedge rst_a)
        if (rst_a) begin
            state <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_nx;
            clr_ptr <= clr_ptr_nx;
        end
    always_comb begin
        state_nx = bus.clear_req ? CLEAR : (state == CLEAR && clr_ptr == LAST) ? READY : state;
        clr_ptr_nx = bus.clear_req ? '0 : (state == CLEAR) ? clr_ptr + ADDR_W'(1) : clr_ptr;
    end
    always_comb busy = (state == CLEAR);
    always_comb begin
        en0 = bus.we0 == REGFILE_WR_ACTIVE && bus.ck_en_w0 == REGFILE_CK_EN_ACTIVE && !busy;
        en1 = bus.we1 == REGFILE_WR_ACTIVE && bus.ck_en_w1 == REGFILE_CK_EN_ACTIVE && !busy;
        eff0 = en0 && IMPL_MASK[bus.address_w0];
        eff1 = en1 && IMPL_MASK[bus.address_w1];
        err0 = en0 && !IMPL_MASK[bus.address_w0];
        err1 = en1 && !IMPL_MASK[bus.address_w1];
    end
    always_ff @(posedge clk or posedge rst_a)
        if (rst_a) wr_err <= 1'b0;
        else wr_err <= err0 || err1;
    // storage exists only for implemented indices; port 1 has priority on a shared index
    for (genvar i = 0; i < N; i++) begin : g_reg
        if (IMPL_MASK[i]) begin : g_impl
            logic [DATA_W-1:0] q;
            always_ff @(posedge clk)
                if (busy && clr_ptr == ADDR_W'(i)) q <= '0;
                else if (eff1 && bus.address_w1 == ADDR_W'(i)) q <= bus.wr_data1;
                else if (eff0 && bus.address_w0 == ADDR_W'(i)) q <= bus.wr_data0;
            assign mem[i] = q;
        end else begin : g_none
            assign mem[i] = '0;
        end
    end
    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMPL_MASK(IMPL_MASK)) u_rd_a (
        .clk(clk), .rst_a(rst_a), .ck_en(bus.ck_en_a), .address(bus.address_a),
        .busy(busy), .mem(mem), .rd_data(bus.rd_data_a)
    );
    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMPL_MASK(IMPL_MASK)) u_rd_b (
        .clk(clk), .rst_a(rst_a), .ck_en(bus.ck_en_b), .address(bus.address_b),
        .busy(busy), .mem(mem), .rd_data(bus.rd_data_b)
    );
    assign bus.busy = busy;
    assign bus.wr_err = wr_err;
`ifndef SYNTHESIS
    always @(posedge clk)
        if (!rst_a) begin
            assert (!$isunknown({bus.we0, bus.we1}));
            if (bus.we0 == REGFILE_WR_ACTIVE) assert (!$isunknown({bus.address_w0, bus.wr_data0}));
            if (bus.we1 == REGFILE_WR_ACTIVE) assert (!$isunknown({bus.address_w1, bus.wr_data1}));
        end
`endif
endmodule

// File: tb/tb_regfile_mp_ff.sv
// tb_regfile_mp_ff: directed self-checking bench for the 2R/2W register file
module tb_regfile_mp_ff;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    int n_assert = 0;
    int n_fail = 0;
    int cnt;
    logic [31:0] mask = 32'hFC00_FC0F;
    regfile_mp_ff_if bus ();
    regfile_mp_ff dut (.clk(clk), .rst_a(rst_a), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic count_busy(input string tag);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        check(tag, cnt, 32);
    endtask

    initial begin
        bus.clear_req = 0; bus.address_a = 0; bus.address_b = 0;
        bus.ck_en_a = 0; bus.ck_en_b = 0;
        bus.address_w0 = 0; bus.address_w1 = 0; bus.wr_data0 = 0; bus.wr_data1 = 0;
        bus.we0 = 0; bus.we1 = 0; bus.ck_en_w0 = 0; bus.ck_en_w1 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, bus.busy}, 1);
        check("rst_wr_err", {31'd0, bus.wr_err}, 0);
        check("rst_rd_a", bus.rd_data_a, 0);
        check("rst_rd_b", bus.rd_data_b, 0);
        rst_a = 0;
        count_busy("rst_clear_len");
        check("ready_busy", {31'd0, bus.busy}, 0);
        bus.ck_en_a = 1; bus.ck_en_b = 1;
        for (int i = 0; i < 32; i++) if (mask[i]) begin
            bus.address_a = 5'(i); bus.address_b = 5'(i);
            tick();
            check($sformatf("clr_a_r%0d", i), bus.rd_data_a, 0);
            check($sformatf("clr_b_r%0d", i), bus.rd_data_b, 0);
        end
        // write r12 while latching its address on the same edge
        bus.address_a = 12; bus.address_w0 = 12; bus.wr_data0 = 32'hDEADBEEF;
        bus.we0 = 1; bus.ck_en_w0 = 1;
        tick();
        bus.we0 = 0;
        check("wr_r12_same_edge", bus.rd_data_a, 32'hDEADBEEF);
        bus.ck_en_a = 0; bus.address_a = 3;
        tick();
        check("addr_hold", bus.rd_data_a, 32'hDEADBEEF);
        // both ports to r3: port 1 wins
        bus.address_b = 3;
        bus.address_w0 = 3; bus.wr_data0 = 32'h11111111;
        bus.address_w1 = 3; bus.wr_data1 = 32'h22222222; bus.ck_en_w1 = 1;
        bus.we0 = 1; bus.we1 = 1;
        tick();
        check("collide_r3", bus.rd_data_b, 32'h22222222);
        bus.ck_en_a = 1; bus.address_a = 1; bus.address_b = 2;
        bus.address_w0 = 1; bus.wr_data0 = 32'h01010101;
        bus.address_w1 = 2; bus.wr_data1 = 32'h02020202;
        tick();
        bus.we0 = 0; bus.we1 = 0;
        check("dual_r1", bus.rd_data_a, 32'h01010101);
        check("dual_r2", bus.rd_data_b, 32'h02020202);
        bus.ck_en_a = 0; bus.wr_data0 = 32'h0BADF00D; bus.we0 = 1;
        tick();
        bus.we0 = 0;
        check("wr_prelatched_r1", bus.rd_data_a, 32'h0BADF00D);
        check("no_err_ok_write", {31'd0, bus.wr_err}, 0);
        // write to unimplemented r5
        bus.address_w0 = 5; bus.wr_data0 = 32'hFFFFFFFF; bus.we0 = 1;
        bus.ck_en_a = 1; bus.address_a = 5;
        tick();
        bus.we0 = 0;
        check("err_set", {31'd0, bus.wr_err}, 1);
        check("rd_unimpl_r5", bus.rd_data_a, 0);
        tick();
        check("err_one_cycle", {31'd0, bus.wr_err}, 0);
        bus.address_w1 = 31; bus.wr_data1 = 32'hA5A5A5A5; bus.we1 = 1; bus.address_a = 31;
        tick();
        bus.we1 = 0;
        check("fill_r31", bus.rd_data_a, 32'hA5A5A5A5);
        bus.clear_req = 1;
        tick();
        bus.clear_req = 0;
        bus.address_w0 = 31; bus.wr_data0 = 32'hFFFFFFFF; bus.we0 = 1;
        bus.address_w1 = 5; bus.wr_data1 = 32'h12345678; bus.we1 = 1;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 100) begin
            if (bus.rd_data_a !== 0 || bus.wr_err !== 0)
                check($sformatf("busy_quiet_c%0d", cnt), {bus.rd_data_a[30:0], bus.wr_err}, 0);
            cnt++;
            tick();
        end
        bus.we0 = 0; bus.we1 = 0;
        check("req_clear_len", cnt, 32);
        check("busy_no_err", {31'd0, bus.wr_err}, 0);
        check("r31_cleared", bus.rd_data_a, 0);
        bus.address_b = 12;
        tick();
        check("r12_cleared", bus.rd_data_b, 0);
        bus.address_w0 = 31; bus.wr_data0 = 32'h5A5A5A5A; bus.we0 = 1;
        tick();
        bus.we0 = 0;
        check("wr_after_clear", bus.rd_data_a, 32'h5A5A5A5A);
        // reset in the middle of a clear sequence
        bus.clear_req = 1;
        tick();
        bus.clear_req = 0;
        repeat (10) tick();
        rst_a = 1;
        #1;
        check("midrst_busy", {31'd0, bus.busy}, 1);
        tick();
        check("midrst_busy_hold", {31'd0, bus.busy}, 1);
        rst_a = 0;
        count_busy("midrst_clear_len");
        tick();
        check("midrst_r31_after", bus.rd_data_a, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
